// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-side push and decode-side pop handshake bundle for fetch_queue
interface fetch_queue_if #(parameter int DATA_WIDTH = 32, parameter int DEPTH = 4);
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [DATA_WIDTH-1:0] in_instr;
  logic [DATA_WIDTH-1:0] in_pc;
  logic [DATA_WIDTH-1:0] in_pc4;
  logic out_valid;
  logic out_ready;
  logic [DATA_WIDTH-1:0] out_instr;
  logic [DATA_WIDTH-1:0] out_pc;
  logic [DATA_WIDTH-1:0] out_pc4;
  logic [$clog2(DEPTH):0] count;
  modport master (
    output flush, in_valid, in_instr, in_pc, in_pc4, out_ready,
    input in_ready, out_valid, out_instr, out_pc, out_pc4, count
  );
  modport slave (
    input flush, in_valid, in_instr, in_pc, in_pc4, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_pc4, count
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: first-word-fall-through instruction buffer between fetch and decode, flushed on redirect
module fetch_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  fetch_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  logic [3*DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0] cnt;
  logic push, pop, full, empty;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign push = q.in_valid & ~full & ~q.flush;
  assign pop = ~empty & q.out_ready & ~q.flush;
  always_ff @(posedge clk) begin
    if (rst || q.flush) begin
      head <= '0;
      tail <= '0;
      cnt <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop) head <= head + AW'(1);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // storage needs no reset: empty queue masks every slot from the outputs
  always_ff @(posedge clk)
    if (!rst && push) mem[tail] <= {q.in_instr, q.in_pc, q.in_pc4};
  always_comb begin
    q.in_ready = ~full;
    q.out_valid = ~empty;
    q.count = cnt;
    {q.out_instr, q.out_pc, q.out_pc4} = empty ? '0 : mem[head];
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue covering reset, fill/drain, wrap, flush and mid-run reset
module tb_fetch_queue;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  logic clk = 0;
  logic rst;
  int errors = 0;
  int checks = 0;
  logic [3*DW-1:0] sb [$];
  fetch_queue_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();
  fetch_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .q(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // drive one cycle, check outputs against the scoreboard, then advance the model over the edge
  task automatic step(input logic r, input logic fl, input logic iv, input logic [DW-1:0] instr,
                      input logic [DW-1:0] pc, input logic ordy);
    logic [3*DW-1:0] head;
    logic do_push, do_pop;
    rst = r;
    bus.flush = fl;
    bus.in_valid = iv;
    bus.in_instr = instr;
    bus.in_pc = pc;
    bus.in_pc4 = pc + 4;
    bus.out_ready = ordy;
    #1;
    head = sb.size() > 0 ? sb[0] : '0;
    chk("count", DW'(bus.count), DW'(sb.size()));
    chk("in_ready", DW'(bus.in_ready), DW'(sb.size() < DEPTH));
    chk("out_valid", DW'(bus.out_valid), DW'(sb.size() > 0));
    chk("out_instr", bus.out_instr, head[3*DW-1:2*DW]);
    chk("out_pc", bus.out_pc, head[2*DW-1:DW]);
    chk("out_pc4", bus.out_pc4, head[DW-1:0]);
    do_push = iv && sb.size() < DEPTH;
    do_pop = ordy && sb.size() > 0;
    if (r || fl) sb.delete();
    else begin
      if (do_pop) void'(sb.pop_front());
      if (do_push) sb.push_back({instr, pc, pc + 32'd4});
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic idle(input logic ordy);
    step(0, 0, 0, '0, '0, ordy);
  endtask
  task automatic push(input logic [DW-1:0] pc, input logic ordy);
    step(0, 0, 1, 32'hA0 + pc / 4, pc, ordy);
  endtask
  initial begin
    rst = 1;
    bus.flush = 0;
    bus.in_valid = 1;
    bus.in_instr = '0;
    bus.in_pc = '0;
    bus.in_pc4 = '0;
    bus.out_ready = 0;
    @(posedge clk);
    @(negedge clk);
    step(1, 0, 1, 32'hA0, 32'h0, 0);
    step(1, 0, 1, 32'hA0, 32'h0, 0);
    for (int i = 0; i < 5; i++) push(32'(4 * i), 0);
    for (int i = 0; i < 5; i++) idle(1);
    push(32'h200, 0);
    push(32'h204, 0);
    for (int i = 0; i < 10; i++) push(32'h208 + 32'(4 * i), 1);
    for (int i = 0; i < 3; i++) idle(1);
    for (int i = 0; i < 3; i++) push(32'h300 + 32'(4 * i), 0);
    step(0, 1, 1, 32'hB0, 32'h40, 1);
    push(32'h80, 0);
    idle(1);
    idle(1);
    push(32'h100, 0);
    idle(0);
    idle(1);
    idle(1);
    for (int i = 0; i < 3; i++) push(32'h500 + 32'(4 * i), 0);
    step(1, 0, 1, 32'hC0, 32'h600, 1);
    idle(1);
    idle(1);
    push(32'h700, 0);
    idle(1);
    idle(1);
    for (int i = 0; i < 300; i++)
      step(0, $urandom_range(0, 19) == 0, 1'($urandom), $urandom, $urandom & 32'hFFFC, 1'($urandom));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
